// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter controller and its count register.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Wide enough for DIV up to 65535 (prescaler runs 0..DIV-1).
    localparam int PRESC_W = 16;

endpackage

// File: rtl/counter_en_nbit.sv
// N-bit count register with synchronous clear and increment enable.
module counter_en_nbit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [N-1:0] count
);

    logic [N-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_ctrl.sv
// Prescaled up-counter controller: start/stop/pause FSM, one-shot or periodic
// terminal count, registered status outputs.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int N   = 8,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic [N-1:0] limit,
    input  logic         periodic,
    output logic [N-1:0] count,
    output logic         busy,
    output logic         paused,
    output logic         done
);

    localparam logic [PRESC_W-1:0] DIV_M1 = PRESC_W'(DIV - 1);

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [N-1:0]         limit_q, limit_d;
    logic                 periodic_q, periodic_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 paused_q, paused_d;
    logic                 cnt_clr, cnt_en;
    logic [N-1:0]         count_w;

    counter_en_nbit #(.N(N)) u_count (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count_w)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            limit_q    <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            paused_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            limit_q    <= limit_d;
            periodic_q <= periodic_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            paused_q   <= paused_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        limit_d    = limit_q;
        periodic_d = periodic_q;
        done_d     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        if (stop) begin
            state_d = IDLE;
            presc_d = '0;
            cnt_clr = 1'b1;
        end else if (start) begin
            state_d    = RUN;
            presc_d    = '0;
            limit_d    = limit;
            periodic_d = periodic;
            cnt_clr    = 1'b1;
        end else if (state_q == RUN || state_q == PAUSE) begin
            if (pause) begin
                state_d = PAUSE;
            end else begin
                // Leaving PAUSE counts in the same cycle, so a pause costs exactly its length.
                state_d = RUN;
                if (presc_q == DIV_M1) begin
                    presc_d = '0;
                    if (count_w == limit_q) begin
                        done_d = 1'b1;
                        if (periodic_q) begin
                            cnt_clr = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        end

        busy_d   = (state_d == RUN) || (state_d == PAUSE);
        paused_d = (state_d == PAUSE);
    end

    assign count  = count_w;
    assign busy   = busy_q;
    assign paused = paused_q;
    assign done   = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed scoreboard bench for counter_ctrl, run with DIV=1 and DIV=4 instances side by side.
module tb_counter_ctrl;

    typedef logic [10:0] obs_t;

    logic       clk = 1'b0;
    logic       reset, start, stop, pause, periodic;
    logic [7:0] limit;

    logic [7:0] c1, c4;
    logic       b1, p1, d1, b4, p4, d4;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int k;
    int d1_last = -1, d1_prev = -1, d1_first = -1;
    int d4_last = -1, d4_prev = -1, d4_first = -1;

    int   m_st [2] = '{0, 0};
    int   m_cnt[2] = '{0, 0};
    int   m_pre[2] = '{0, 0};
    int   m_lim[2] = '{0, 0};
    bit   m_per[2] = '{0, 0};
    int   divs [2] = '{1, 4};

    obs_t q1[$];
    obs_t q4[$];

    always #5 clk = ~clk;

    counter_ctrl #(.N(8), .DIV(1)) u_d1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .limit(limit), .periodic(periodic),
        .count(c1), .busy(b1), .paused(p1), .done(d1)
    );

    counter_ctrl #(.N(8), .DIV(4)) u_d4 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .limit(limit), .periodic(periodic),
        .count(c4), .busy(b4), .paused(p4), .done(d4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    // Behavioural reference: state 0 idle, 1 run, 2 pause, 3 done.
    task automatic model(input int i, input logic rst, input logic st, input logic sp,
                         input logic pa, input logic [7:0] lim, input logic per,
                         output obs_t e);
        logic dn;
        dn = 1'b0;
        if (rst) begin
            m_st[i] = 0; m_cnt[i] = 0; m_pre[i] = 0; m_lim[i] = 0; m_per[i] = 0;
        end else if (sp) begin
            m_st[i] = 0; m_cnt[i] = 0; m_pre[i] = 0;
        end else if (st) begin
            m_st[i] = 1; m_cnt[i] = 0; m_pre[i] = 0; m_lim[i] = int'(lim); m_per[i] = per;
        end else if (m_st[i] == 1 || m_st[i] == 2) begin
            if (pa) begin
                m_st[i] = 2;
            end else begin
                m_st[i] = 1;
                if (m_pre[i] == divs[i] - 1) begin
                    m_pre[i] = 0;
                    if (m_cnt[i] == m_lim[i]) begin
                        dn = 1'b1;
                        if (m_per[i]) m_cnt[i] = 0;
                        else          m_st[i] = 3;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else begin
                    m_pre[i] = m_pre[i] + 1;
                end
            end
        end
        e = {8'(m_cnt[i]), (m_st[i] == 1 || m_st[i] == 2), (m_st[i] == 2), dn};
    endtask

    task automatic step(input logic rst, input logic st, input logic sp, input logic pa,
                        input logic [7:0] lim, input logic per);
        obs_t e;
        reset = rst; start = st; stop = sp; pause = pa; limit = lim; periodic = per;
        model(0, rst, st, sp, pa, lim, per, e); q1.push_back(e);
        model(1, rst, st, sp, pa, lim, per, e); q4.push_back(e);
        @(posedge clk);
        cyc++;
        #1;
        if (q1.size() == 0) begin
            total++;
            $error("FAIL sb_d1 cyc=%0d observed=empty-queue expected=entry", cyc);
        end else begin
            e = q1.pop_front();
            chk("sb_d1 {count,busy,paused,done}", 32'({c1, b1, p1, d1}), 32'(e));
        end
        if (q4.size() == 0) begin
            total++;
            $error("FAIL sb_d4 cyc=%0d observed=empty-queue expected=entry", cyc);
        end else begin
            e = q4.pop_front();
            chk("sb_d4 {count,busy,paused,done}", 32'({c4, b4, p4, d4}), 32'(e));
        end
        if (d1 === 1'b1) begin
            d1_prev = d1_last; d1_last = cyc;
            if (d1_first < 0) d1_first = cyc;
        end
        if (d4 === 1'b1) begin
            d4_prev = d4_last; d4_last = cyc;
            if (d4_first < 0) d4_first = cyc;
        end
    endtask

    // Idle cycles with limit/periodic wiggling; they must be ignored outside start.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic start_run(input logic [7:0] lim, input logic per);
        d1_first = -1; d4_first = -1;
        step(1'b0, 1'b1, 1'b0, 1'b0, lim, per);
        k = cyc;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; limit = '0; periodic = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("reset_outputs", 32'({c1, b1, p1, d1}), 32'd0);

        // One-shot, limit 5, DIV=1
        start_run(8'd5, 1'b0);
        chk("start_latency_busy", 32'(b1), 32'd1);
        chk("start_latency_count", 32'(c1), 32'd0);
        run(10);
        chk("oneshot_done_latency", 32'(d1_first - k), 32'd6);
        chk("oneshot_hold_count", 32'(c1), 32'd5);
        chk("oneshot_not_busy", 32'(b1), 32'd0);

        // Periodic, limit 2: DIV=4 period 12, DIV=1 period 3
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        start_run(8'd2, 1'b1);
        run(40);
        chk("periodic_d4_first", 32'(d4_first - k), 32'd12);
        chk("periodic_d4_period", 32'(d4_last - d4_prev), 32'd12);
        chk("periodic_d4_busy", 32'(b4), 32'd1);
        chk("periodic_d1_period", 32'(d1_last - d1_prev), 32'd3);

        // Pause for 3 cycles at count 4
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        start_run(8'd10, 1'b0);
        run(4);
        chk("pause_pre_count", 32'(c1), 32'd4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b1);
        chk("pause_paused", 32'(p1), 32'd1);
        chk("pause_hold_count", 32'(c1), 32'd4);
        run(15);
        chk("pause_done_late", 32'(d1_first - k), 32'd14);

        // stop and start together: stop wins
        start_run(8'd20, 1'b0);
        run(7);
        chk("stopstart_pre_count", 32'(c1), 32'd7);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'd20, 1'b0);
        chk("stopstart_busy", 32'(b1), 32'd0);
        chk("stopstart_count", 32'(c1), 32'd0);
        run(3);
        chk("stopstart_no_done", 32'(d1_first), 32'hFFFF_FFFF);

        // limit 0 periodic, then limit 255 one-shot
        start_run(8'd0, 1'b1);
        run(5);
        chk("lim0_done", 32'(d1), 32'd1);
        chk("lim0_count", 32'(c1), 32'd0);
        chk("lim0_period", 32'(d1_last - d1_prev), 32'd1);
        start_run(8'd255, 1'b0);
        run(260);
        chk("lim255_done_latency", 32'(d1_first - k), 32'd256);
        chk("lim255_count", 32'(c1), 32'd255);

        // reset mid-run, then fresh start
        start_run(8'd50, 1'b0);
        run(9);
        chk("midreset_pre_count", 32'(c1), 32'd9);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("midreset_outputs", 32'({c1, b1, p1, d1}), 32'd0);
        start_run(8'd3, 1'b0);
        run(6);
        chk("fresh_done_latency", 32'(d1_first - k), 32'd4);
        chk("fresh_count", 32'(c1), 32'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d observed=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
